// File: rtl/read_data_control.sv
// Receives PSL buffer-write half-lines into per-tag RAMs and emits the full 128-byte line when the tag's response arrives.
// Latency: line and incomplete error appear 2 edges after the response is sampled; parity errors 1 edge after stage R.
// No backpressure; inputs are ignored while enabled_i is low. Parity checking is built only with READ_DATA_PARITY_CHECK_EN.
module read_data_control #(
    parameter int TAG_DEPTH  = 256,
    parameter int DATA_WIDTH = 512
) (
    input  logic                     clock_i,
    input  logic                     rst_i,
    input  logic                     enabled_i,
    input  logic                     buffer_write_valid_i,
    input  logic [7:0]               buffer_write_tag_i,
    input  logic                     buffer_write_tag_parity_i,
    input  logic [5:0]               buffer_write_address_i,
    input  logic [DATA_WIDTH-1:0]    buffer_write_data_i,
    input  logic [DATA_WIDTH/64-1:0] buffer_write_parity_i,
    input  logic                     response_valid_i,
    input  logic [7:0]               response_tag_i,
    input  logic                     response_ok_i,
    output logic                     read_data_valid_o,
    output logic [7:0]               read_data_tag_o,
    output logic [DATA_WIDTH-1:0]    read_data_0_o,
    output logic [DATA_WIDTH-1:0]    read_data_1_o,
    output logic [2:0]               data_read_error_o
);

    localparam int TAG_W = $clog2(TAG_DEPTH);
    localparam int NDW   = DATA_WIDTH / 64;

    // Stage R input registers
    logic                  wr_vld_q;
    logic [7:0]            wr_tag_q;
    logic                  wr_half_q;
    logic [DATA_WIDTH-1:0] wr_dat_q;
    logic                  rsp_vld_q;
    logic [7:0]            rsp_tag_q;
    logic                  rsp_ok_q;

    logic [DATA_WIDTH-1:0] ram0_q [TAG_DEPTH];
    logic [DATA_WIDTH-1:0] ram1_q [TAG_DEPTH];
    logic [TAG_DEPTH-1:0]  arr0_q, arr0_d;
    logic [TAG_DEPTH-1:0]  arr1_q, arr1_d;

    logic                  s1_vld_q;
    logic                  s1_inc_q;
    logic [7:0]            s1_tag_q;
    logic [DATA_WIDTH-1:0] rd0_q, rd1_q;

    logic                  out_vld_q;
    logic                  out_inc_q;
    logic [7:0]            out_tag_q;
    logic [DATA_WIDTH-1:0] out_d0_q, out_d1_q;

    logic [TAG_W-1:0] wr_idx, rsp_idx;
    logic             same_tag, have0, have1, line_ok, line_bad;

    assign wr_idx   = wr_tag_q[TAG_W-1:0];
    assign rsp_idx  = rsp_tag_q[TAG_W-1:0];
    assign same_tag = wr_vld_q && rsp_vld_q && (wr_tag_q == rsp_tag_q);
    // A write committing this cycle counts toward completeness of its own tag
    assign have0    = arr0_q[rsp_idx] || (same_tag && !wr_half_q);
    assign have1    = arr1_q[rsp_idx] || (same_tag && wr_half_q);
    assign line_ok  = rsp_vld_q && rsp_ok_q && have0 && have1;
    assign line_bad = rsp_vld_q && rsp_ok_q && !(have0 && have1);

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            wr_vld_q  <= 1'b0;
            wr_tag_q  <= '0;
            wr_half_q <= 1'b0;
            wr_dat_q  <= '0;
            rsp_vld_q <= 1'b0;
            rsp_tag_q <= '0;
            rsp_ok_q  <= 1'b0;
        end else begin
            wr_vld_q  <= buffer_write_valid_i && enabled_i;
            rsp_vld_q <= response_valid_i && enabled_i;
            if (buffer_write_valid_i && enabled_i) begin
                wr_tag_q  <= buffer_write_tag_i;
                wr_half_q <= (buffer_write_address_i != 6'd0);
                wr_dat_q  <= buffer_write_data_i;
            end
            if (response_valid_i && enabled_i) begin
                rsp_tag_q <= response_tag_i;
                rsp_ok_q  <= response_ok_i;
            end
        end
    end

    // Response clears after the write sets, so a same-tag write is consumed by the line
    always_comb begin
        arr0_d = arr0_q;
        arr1_d = arr1_q;
        if (wr_vld_q) begin
            if (wr_half_q) arr1_d[wr_idx] = 1'b1;
            else           arr0_d[wr_idx] = 1'b1;
        end
        if (rsp_vld_q) begin
            arr0_d[rsp_idx] = 1'b0;
            arr1_d[rsp_idx] = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_vld_q) begin
            if (wr_half_q) ram1_q[wr_idx] <= wr_dat_q;
            else           ram0_q[wr_idx] <= wr_dat_q;
        end
        if (line_ok) begin
            rd0_q <= (same_tag && !wr_half_q) ? wr_dat_q : ram0_q[rsp_idx];
            rd1_q <= (same_tag && wr_half_q)  ? wr_dat_q : ram1_q[rsp_idx];
        end
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            arr0_q    <= '0;
            arr1_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_inc_q  <= 1'b0;
            s1_tag_q  <= '0;
            out_vld_q <= 1'b0;
            out_inc_q <= 1'b0;
            out_tag_q <= '0;
            out_d0_q  <= '0;
            out_d1_q  <= '0;
        end else begin
            arr0_q    <= arr0_d;
            arr1_q    <= arr1_d;
            s1_vld_q  <= line_ok;
            s1_inc_q  <= line_bad;
            s1_tag_q  <= rsp_tag_q;
            out_vld_q <= s1_vld_q;
            out_inc_q <= s1_inc_q;
            out_tag_q <= s1_vld_q ? s1_tag_q : 8'd0;
            out_d0_q  <= s1_vld_q ? rd0_q : {DATA_WIDTH{1'b1}};
            out_d1_q  <= s1_vld_q ? rd1_q : {DATA_WIDTH{1'b1}};
        end
    end

`ifdef READ_DATA_PARITY_CHECK_EN
    logic             wr_tagpar_q;
    logic [NDW-1:0]   wr_par_q;
    logic [1:0]       par_err_q, par_err_d;

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            wr_tagpar_q <= 1'b0;
            wr_par_q    <= '0;
        end else if (buffer_write_valid_i && enabled_i) begin
            wr_tagpar_q <= buffer_write_tag_parity_i;
            wr_par_q    <= buffer_write_parity_i;
        end
    end

    // Odd parity: each parity bit must equal the XNOR of its covered bits
    always_comb begin
        par_err_d = 2'b00;
        if (wr_vld_q) begin
            par_err_d[0] = (wr_tagpar_q != ~^wr_tag_q);
            for (int i = 0; i < NDW; i++) begin
                if (wr_par_q[i] != ~^wr_dat_q[i*64 +: 64]) par_err_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) par_err_q <= 2'b00;
        else       par_err_q <= par_err_d;
    end

    assign data_read_error_o = {out_inc_q, par_err_q};
`else
    logic unused_par;
    assign unused_par        = ^{buffer_write_tag_parity_i, buffer_write_parity_i};
    assign data_read_error_o = {out_inc_q, 2'b00};
`endif

    assign read_data_valid_o = out_vld_q;
    assign read_data_tag_o   = out_tag_q;
    assign read_data_0_o     = out_d0_q;
    assign read_data_1_o     = out_d1_q;

endmodule

// File: tb/tb_read_data_control.sv
// Bench for read_data_control: directed scenarios plus random traffic checked against a per-tag transaction model.
module tb_read_data_control;

    logic         clock = 1'b0;
    logic         rst, enabled;
    logic         buffer_write_valid, buffer_write_tag_parity, response_valid, response_ok;
    logic [7:0]   buffer_write_tag, buffer_write_parity, response_tag, read_data_tag;
    logic [5:0]   buffer_write_address;
    logic [511:0] buffer_write_data, read_data_0, read_data_1;
    logic         read_data_valid;
    logic [2:0]   data_read_error;

    always #5 clock = ~clock;

    read_data_control dut (
        .clock_i(clock), .rst_i(rst), .enabled_i(enabled),
        .buffer_write_valid_i(buffer_write_valid), .buffer_write_tag_i(buffer_write_tag),
        .buffer_write_tag_parity_i(buffer_write_tag_parity), .buffer_write_address_i(buffer_write_address),
        .buffer_write_data_i(buffer_write_data), .buffer_write_parity_i(buffer_write_parity),
        .response_valid_i(response_valid), .response_tag_i(response_tag), .response_ok_i(response_ok),
        .read_data_valid_o(read_data_valid), .read_data_tag_o(read_data_tag),
        .read_data_0_o(read_data_0), .read_data_1_o(read_data_1), .data_read_error_o(data_read_error)
    );

    typedef struct {
        bit rst; bit en;
        bit wv; bit [7:0] wt; bit wtp; bit [5:0] wa; bit [511:0] wd; bit [7:0] wp;
        bit rv; bit [7:0] rt; bit rok;
    } stim_t;

    typedef struct {
        bit vld; bit [7:0] tag; bit [511:0] d0; bit [511:0] d1; bit [2:0] err;
    } exp_t;

    int       n_chk = 0;
    int       n_fail = 0;
    int       cyc = 0;
    bit [511:0] mem0 [256];
    bit [511:0] mem1 [256];
    bit       have0 [256];
    bit       have1 [256];
    exp_t     ring [4];
    exp_t     cur;
    stim_t    seq [$];

    function automatic exp_t dflt();
        exp_t e;
        e.vld = 0; e.tag = 0; e.d0 = '1; e.d1 = '1; e.err = 0;
        return e;
    endfunction

    function automatic bit [7:0] gpar(input bit [511:0] d);
        bit [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ~^d[i*64 +: 64];
        return p;
    endfunction

    function automatic bit [511:0] rnd512();
        bit [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.en = 1;
        return s;
    endfunction

    function automatic stim_t wr(input bit [7:0] t, input bit [5:0] a, input bit [511:0] d);
        stim_t s;
        s = idle();
        s.wv = 1; s.wt = t; s.wtp = ~^t; s.wa = a; s.wd = d; s.wp = gpar(d);
        return s;
    endfunction

    function automatic stim_t rsp(input stim_t b, input bit [7:0] t, input bit ok);
        stim_t s;
        s = b;
        s.rv = 1; s.rt = t; s.rok = ok;
        return s;
    endfunction

    // Drive one cycle, advance the model, and leave its expectation for this edge in cur
    task automatic step(input stim_t s);
        int k;
        rst = s.rst; enabled = s.en;
        buffer_write_valid = s.wv; buffer_write_tag = s.wt; buffer_write_tag_parity = s.wtp;
        buffer_write_address = s.wa; buffer_write_data = s.wd; buffer_write_parity = s.wp;
        response_valid = s.rv; response_tag = s.rt; response_ok = s.rok;
        @(posedge clock);
        cyc++;
        k = cyc;
        if (s.rst) begin
            for (int i = 0; i < 256; i++) begin have0[i] = 0; have1[i] = 0; end
            for (int i = 0; i < 4; i++) ring[i] = dflt();
            ring[k % 4].d0 = '0;
            ring[k % 4].d1 = '0;
        end else if (s.en) begin
            if (s.wv) begin
                if (s.wa != 0) begin mem1[s.wt] = s.wd; have1[s.wt] = 1; end
                else           begin mem0[s.wt] = s.wd; have0[s.wt] = 1; end
`ifdef READ_DATA_PARITY_CHECK_EN
                if (s.wtp != ~^s.wt) ring[(k + 1) % 4].err[0] = 1;
                if (s.wp != gpar(s.wd)) ring[(k + 1) % 4].err[1] = 1;
`endif
            end
            if (s.rv) begin
                if (s.rok && have0[s.rt] && have1[s.rt]) begin
                    ring[(k + 2) % 4].vld = 1;
                    ring[(k + 2) % 4].tag = s.rt;
                    ring[(k + 2) % 4].d0  = mem0[s.rt];
                    ring[(k + 2) % 4].d1  = mem1[s.rt];
                end else if (s.rok) begin
                    ring[(k + 2) % 4].err[2] = 1;
                end
                have0[s.rt] = 0;
                have1[s.rt] = 0;
            end
        end
        #1;
        cur = ring[k % 4];
        ring[k % 4] = dflt();
    endtask

    task automatic test_reset();
        stim_t s;
        s = idle(); s.rst = 1;
        seq = {s, s, idle(), idle()};
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL reset ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL reset d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL reset d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
        end
    endtask

    task automatic test_full_line();
        seq = {wr(8'h05, 6'd0, {64{8'hA5}}), wr(8'h05, 6'd1, {64{8'h3C}}), rsp(idle(), 8'h05, 1),
               idle(), idle(), idle()};
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL full_line ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL full_line d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL full_line d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
            // The directed line must appear exactly two edges after the response step
            if (i == 4) begin
                n_chk++;
                if (read_data_valid !== 1'b1 || read_data_tag !== 8'h05 || read_data_0 !== {64{8'hA5}}) begin
                    n_fail++;
                    $display("FAIL full_line timing got vld=%b tag=%h exp vld=1 tag=05", read_data_valid, read_data_tag);
                end
            end
        end
    endtask

    task automatic test_incomplete();
        seq = {wr(8'h10, 6'd0, rnd512()), rsp(idle(), 8'h10, 1), idle(), idle(), idle()};
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL incomplete ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL incomplete d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL incomplete d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
        end
    endtask

    task automatic test_parity();
        stim_t a, b;
        a = wr(8'h20, 6'd0, rnd512()); a.wtp = ~a.wtp;
        b = wr(8'h20, 6'd1, rnd512()); b.wp[0] = ~b.wp[0];
        seq = {a, idle(), b, idle(), rsp(idle(), 8'h20, 1), idle(), idle(), idle()};
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL parity ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL parity d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL parity d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
        end
    endtask

    task automatic test_bypass();
        seq = {wr(8'h07, 6'd0, rnd512()), rsp(wr(8'h07, 6'd5, rnd512()), 8'h07, 1), idle(), idle(), idle()};
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL bypass ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL bypass d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL bypass d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
        end
    endtask

    task automatic test_back_to_back();
        seq = {};
        for (int t = 1; t <= 3; t++) begin
            seq.push_back(wr(8'(t), 6'd0, rnd512()));
            seq.push_back(wr(8'(t), 6'd1, rnd512()));
        end
        seq.push_back(wr(8'h02, 6'd1, rnd512()));  // duplicate overwrites half 1 of tag 2
        for (int t = 1; t <= 3; t++) seq.push_back(rsp(idle(), 8'(t), 1));
        seq.push_back(rsp(idle(), 8'h01, 1));
        for (int i = 0; i < 3; i++) seq.push_back(idle());
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL back_to_back ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL back_to_back d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL back_to_back d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
        end
    endtask

    task automatic test_reset_mid();
        stim_t r, off, off_rsp;
        r = idle(); r.rst = 1;
        off = idle(); off.en = 0;
        off_rsp = rsp(off, 8'h0A, 1);
        seq = {wr(8'h09, 6'd0, rnd512()), wr(8'h09, 6'd1, rnd512()), rsp(idle(), 8'h09, 1), r,
               idle(), idle(), rsp(idle(), 8'h09, 1), idle(), idle(),
               // a disabled cycle drops its inputs but lets the in-flight line finish
               wr(8'h0A, 6'd0, rnd512()), wr(8'h0A, 6'd1, rnd512()), off_rsp, idle(),
               rsp(idle(), 8'h0A, 1), off, off, idle()};
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL reset_mid ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL reset_mid d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL reset_mid d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
        end
    endtask

    task automatic test_random();
        stim_t s;
        seq = {};
        for (int i = 0; i < 400; i++) begin
            s = idle();
            if ($urandom_range(99) < 60) begin
                s = wr(8'($urandom_range(7)), 6'($urandom_range(3)), rnd512());
                if ($urandom_range(15) == 0) s.wtp = ~s.wtp;
                if ($urandom_range(15) == 0) s.wp[$urandom_range(7)] ^= 1'b1;
            end
            if ($urandom_range(99) < 40) s = rsp(s, 8'($urandom_range(7)), $urandom_range(5) != 0);
            s.en  = ($urandom_range(9) != 0);
            s.rst = ($urandom_range(99) == 0);
            seq.push_back(s);
        end
        for (int i = 0; i < 3; i++) seq.push_back(idle());
        foreach (seq[i]) begin
            step(seq[i]);
            n_chk += 3;
            if ({read_data_valid, read_data_tag, data_read_error} !== {cur.vld, cur.tag, cur.err}) begin
                n_fail++;
                $display("FAIL random ctl cyc=%0d got vld=%b tag=%h err=%b exp vld=%b tag=%h err=%b", cyc, read_data_valid, read_data_tag, data_read_error, cur.vld, cur.tag, cur.err);
            end
            if (read_data_0 !== cur.d0) begin n_fail++; $display("FAIL random d0 cyc=%0d got %h exp %h", cyc, read_data_0, cur.d0); end
            if (read_data_1 !== cur.d1) begin n_fail++; $display("FAIL random d1 cyc=%0d got %h exp %h", cyc, read_data_1, cur.d1); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ring[i] = dflt();
        test_reset();
        test_full_line();
        test_incomplete();
        test_parity();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/read_data_control.md
Name: read_data_control

Overview:
- Receive side of the PSL buffer-write interface (ha_bwvalid/ha_bwtag/ha_bwad/ha_bwdata/ha_bwpar). PSL uses this interface to deliver read-command data into the AFU.
- Checks tag and data parity, stores each 64-byte half-line in per-tag RAM, and tracks which halves have arrived per tag.
- On a successful response for a tag, emits the assembled 128-byte cache line to the engine. This is the counterpart to the block that serves PSL buffer reads for write commands.

Parameters:
- TAG_DEPTH, 256, number of tag entries in each half-line RAM and in the arrival bitmap.
- DATA_WIDTH, 512, bits per half-line.

Ports:
- clock  in  1  single clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enabled  in  1  block enable; inputs ignored when low
- buffer_write_valid  in  1  ha_bwvalid
- buffer_write_tag  in  8  ha_bwtag
- buffer_write_tag_parity  in  1  ha_bwtagpar, odd
- buffer_write_address  in  6  ha_bwad; 0 = half 0, nonzero = half 1
- buffer_write_data  in  512  ha_bwdata
- buffer_write_parity  in  8  ha_bwpar, one odd-parity bit per 64-bit double word, bit 0 covers data[0:63]
- response_valid  in  1  command response for a read command
- response_tag  in  8  tag of the response
- response_ok  in  1  response code is DONE
- read_data_valid  out  1  one-cycle pulse, assembled line valid
- read_data_tag  out  8  tag of the emitted line
- read_data_0  out  512  half 0
- read_data_1  out  512  half 1
- data_read_error  out  3  [0] tag parity, [1] data parity, [2] incomplete line

Behaviour:
- Reset (rst high at an edge): all outputs 0, input registers 0, arrival bitmap cleared. RAM contents are not reset.
- Stage R (input register): buffer_write_* are captured when buffer_write_valid && enabled; otherwise the captured valid is 0. response_* are captured when response_valid && enabled.
- Write commit (same cycle as stage R): if the captured write is valid, write the data into the half-0 or half-1 RAM at the tag address and set bitmap[tag][half].
- Parity:
  - Expected tag parity = ~^tag.
  - Expected parity bit per double word = ~^dw.
  - Any mismatch on a captured write pulses the matching data_read_error bit for one cycle, one cycle after stage R.
  - A write with a parity error is still stored.
- Response evaluation (stage R):
  - If response_ok is set and both bitmap bits of the tag are set, the line is complete. Completeness includes a write committing to the same tag in the same cycle; that write bypasses into both the bitmap check and the data read path.
  - Complete line: read both RAMs at the tag (registered read). read_data_valid, read_data_tag, read_data_0 and read_data_1 are valid for exactly one cycle, two edges after response_valid is sampled. Both bitmap bits of the tag are cleared.
  - response_ok with a missing half: no output. data_read_error[2] pulses with the same timing as read_data_valid. Both bitmap bits of the tag are cleared.
  - response_ok low: clear the tag's bitmap bits; no output, no error.
- When read_data_valid is low, read_data_0 and read_data_1 are driven to all ones and read_data_tag is 0.
- Back-to-back responses on consecutive cycles are fully pipelined: one line per cycle, in order.
- A duplicate write to the same tag and half overwrites the stored data; the bitmap bit stays set.
- enabled low: no captures and no new outputs. Pipeline stages already in flight complete.
- rst asserted mid-operation: in-flight outputs are squashed on the next edge and the bitmap is cleared.

Optional Feature:
- READ_DATA_PARITY_CHECK_EN defined: tag and data parity are checked as above.
- Not defined: parity logic is removed and data_read_error[1:0] are tied to 0. Incomplete-line detection remains.

Test Plan:
- Write tag 0x05: addr 0 with data all 0xA5 and correct parity, then addr 1 with data all 0x3C; then response_valid, tag 0x05, ok=1 -> read_data_valid high exactly 2 cycles later, read_data_tag=0x05, read_data_0=all 0xA5, read_data_1=all 0x3C.
- Write tag 0x10 addr 0 only, then response ok -> no read_data_valid; data_read_error=3'b100 for one cycle.
- Write tag 0x20 with buffer_write_tag_parity inverted, then a separate write with bit 0 of buffer_write_parity inverted -> data_read_error[0] pulses, then data_read_error[1] pulses, one cycle after each capture. Without the macro defined, both stay 0.
- Same-cycle case: second half of tag 0x07 presented at the same edge as the response for 0x07 -> line emitted, read_data_1 equals the bypassed data.
- Full lines for tags 0x01, 0x02, 0x03, then responses on three consecutive cycles -> three consecutive read_data_valid pulses with tags 1, 2, 3. A repeat response for tag 1 then gives the incomplete error.
- rst asserted one cycle after a response -> read_data_valid stays 0. After reset, a response for the same tag gives the incomplete error.
